// File: rtl/xor_share_pkg.sv
// Shared types and helpers for the xor_share_arbiter block: FSM state encoding
// and the round-robin winner search used by the arbiter.
package xor_share_pkg;

    // Upper bound on requester count; sizes the generic round-robin search.
    localparam int MAX_REQ  = 16;
    localparam int MAX_ID_W = 4;

    // Response-slot state: IDLE holds nothing, HOLD presents a result.
    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    // Result of a round-robin search: found flag plus winning index.
    typedef struct packed {
        logic                found;
        logic [MAX_ID_W-1:0] index;
    } pick_t;

    // Return the first set bit of valid scanning ptr, ptr+1, ... modulo
    // num_req. Bits at or above num_req are ignored.
    function automatic pick_t rr_pick(
        input logic [MAX_REQ-1:0]  valid,
        input logic [MAX_ID_W-1:0] ptr,
        input int                  num_req
    );
        pick_t               res;
        logic [MAX_ID_W-1:0] idx;
        int                  pos;
        // NOTE: combinational code (functions, always_comb) uses blocking '='
        // so each statement sees the value computed by the one before it.
        res = '0;
        for (int k = 0; k < MAX_REQ; k++) begin
            // ptr < num_req and k < num_req, so one subtraction wraps it.
            pos = int'(ptr) + k;
            if (pos >= num_req) begin
                pos = pos - num_req;
            end
            idx = MAX_ID_W'(pos);
            if ((k < num_req) && !res.found && valid[idx]) begin
                res.found = 1'b1;
                res.index = idx;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/xor_gate.sv
// Single-bit XOR cell of the shared datapath; replicated WIDTH times by the
// arbiter to form the full-width operator.
module xor_gate (
    input  logic a,
    input  logic b,
    output logic y
);

    assign y = a ^ b;

endmodule

// File: rtl/xor_share_arbiter.sv
// Shares one registered XOR datapath between NUM_REQ requesters. A round-robin
// scheduler grants one requester per issue; the result and winner ID are held
// in a single-entry response slot with a valid/ready handshake. A completed
// response counter tracks rsp_valid & rsp_ready events.
module xor_share_arbiter
    import xor_share_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8,
    parameter int ID_W    = $clog2(NUM_REQ),
    parameter int CNT_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [WIDTH-1:0]         rsp_data,
    output logic [CNT_W-1:0]         op_count
);

    state_e           state;
    state_e           state_next;
    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  next_ptr;
    pick_t            pick;
    logic [ID_W-1:0]  win_id;
    logic             can_issue;
    logic             grant;
    logic [WIDTH-1:0] win_a;
    logic [WIDTH-1:0] win_b;
    logic [WIDTH-1:0] xor_y;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------

    // Round-robin search starting at rr_ptr; the pointer names the requester
    // with highest priority for the next issue.
    assign pick   = rr_pick(MAX_REQ'(req_valid), MAX_ID_W'(rr_ptr), NUM_REQ);
    assign win_id = ID_W'(pick.index);

    // Pointer moves to the requester just after the winner, wrapping at
    // NUM_REQ (which need not be a power of two).
    always_comb begin
        next_ptr = '0;
        if (int'(win_id) != NUM_REQ - 1) begin
            next_ptr = win_id + 1'b1;
        end
    end

    // FSM next state and issue decision. A new result may be issued when the
    // slot is empty or is being drained in this very cycle.
    always_comb begin
        // NOTE: every signal written here gets a default first; a path that
        // leaves one unassigned would infer a latch.
        state_next = state;
        can_issue  = 1'b0;
        grant      = 1'b0;
        unique case (state)
            IDLE:    can_issue = 1'b1;
            HOLD:    can_issue = rsp_ready;
            default: can_issue = 1'b0;
        endcase
        grant = can_issue & pick.found;
        if (grant) begin
            state_next = HOLD;
        end else if ((state == HOLD) && rsp_ready) begin
            state_next = IDLE;
        end
    end

    // One-hot accept to the winner. Gated by rst_n so nothing is accepted
    // while the block is held in reset.
    always_comb begin
        req_ready = '0;
        if (grant && rst_n) begin
            req_ready[win_id] = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Shared datapath
    // ------------------------------------------------------------------

    // Route the winner's operands into the shared XOR cells.
    always_comb begin
        win_a = req_a[win_id*WIDTH +: WIDTH];
        win_b = req_b[win_id*WIDTH +: WIDTH];
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_xor
        xor_gate u_xor (
            .a (win_a[i]),
            .b (win_b[i]),
            .y (xor_y[i])
        );
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------

    // Response slot occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking '<=' so all flops update
        // together from values sampled before the edge.
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    assign rsp_valid = (state == HOLD);

    // Capture result, owner ID and advance the priority pointer on a grant;
    // otherwise the slot contents and pointer are held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_data <= '0;
            rsp_id   <= '0;
            rr_ptr   <= '0;
        end else if (grant) begin
            rsp_data <= xor_y;
            rsp_id   <= win_id;
            rr_ptr   <= next_ptr;
        end
    end

    // Count completed responses; wraps naturally at 2^CNT_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count <= '0;
        end else if (rsp_valid && rsp_ready) begin
            op_count <= op_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_xor_share_arbiter.sv
// Testbench for xor_share_arbiter: a behavioural model tracks the expected
// response slot, priority pointer and counter and is compared against the DUT
// on every falling edge, alongside directed vectors with literal expectations.
module tb_xor_share_arbiter;

    localparam int NUM_REQ = 4;
    localparam int WIDTH   = 8;
    localparam int ID_W    = 2;
    localparam int CNT_W   = 16;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic [NUM_REQ-1:0]       req_valid = '0;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_a = '0;
    logic [NUM_REQ*WIDTH-1:0] req_b = '0;
    logic                     rsp_valid;
    logic                     rsp_ready = 1'b0;
    logic [ID_W-1:0]          rsp_id;
    logic [WIDTH-1:0]         rsp_data;
    logic [CNT_W-1:0]         op_count;

    int n_vec = 0;
    int n_err = 0;

    xor_share_arbiter #(
        .NUM_REQ (NUM_REQ),
        .WIDTH   (WIDTH),
        .CNT_W   (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .op_count  (op_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    logic        m_hold  = 1'b0;
    int          m_id    = 0;
    logic [7:0]  m_data  = '0;
    int          m_ptr   = 0;
    logic [15:0] m_count = '0;
    int          m_win;

    // First valid requester in the order ptr, ptr+1, ... (mod NUM_REQ), or -1.
    function automatic int model_pick(input logic [NUM_REQ-1:0] v, input int ptr);
        int j;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = (ptr + k) % NUM_REQ;
            if (v[j[1:0]]) return j;
        end
        return -1;
    endfunction

    always_comb m_win = (!m_hold || rsp_ready) ? model_pick(req_valid, m_ptr) : -1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_hold  <= 1'b0;
            m_id    <= 0;
            m_data  <= '0;
            m_ptr   <= 0;
            m_count <= '0;
        end else begin
            if (m_hold && rsp_ready) m_count <= m_count + 16'd1;
            if (m_win >= 0) begin
                m_hold <= 1'b1;
                m_id   <= m_win;
                m_data <= 8'(req_a >> (m_win * WIDTH)) ^ 8'(req_b >> (m_win * WIDTH));
                m_ptr  <= (m_win + 1) % NUM_REQ;
            end else if (rsp_ready) begin
                m_hold <= 1'b0;
            end
        end
    end

    // Compare process: every falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_req_ready", 32'(req_ready), 32'd0);
            check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
            check("rst_op_count", 32'(op_count), 32'd0);
        end else begin
            check("req_ready", 32'(req_ready), (m_win >= 0) ? (32'd1 << m_win) : 32'd0);
            check("rsp_valid", 32'(rsp_valid), 32'(m_hold));
            if (m_hold) begin
                check("rsp_id", 32'(rsp_id), 32'(m_id));
                check("rsp_data", 32'(rsp_data), 32'(m_data));
            end
            check("op_count", 32'(op_count), 32'(m_count));
        end
    end

    // ------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
        req_a[i*WIDTH +: WIDTH] = a;
        req_b[i*WIDTH +: WIDTH] = b;
    endtask

    initial begin
        int rr_exp [8];
        rr_exp = '{0, 1, 2, 3, 0, 1, 2, 3};

        // Reset then idle.
        @(negedge clk);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_op_count", 32'(op_count), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("idle_req_ready", 32'(req_ready), 32'b0000);
        check("idle_rsp_valid", 32'(rsp_valid), 32'd0);
        step();

        // Single request.
        set_op(0, 8'hA5, 8'h0F);
        req_valid = 4'b0001;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("single_grant", 32'(req_ready), 32'b0001);
        step();
        req_valid = 4'b0000;
        @(negedge clk);
        check("single_valid", 32'(rsp_valid), 32'd1);
        check("single_id", 32'(rsp_id), 32'd0);
        check("single_data", 32'(rsp_data), 32'hAA);
        step();
        @(negedge clk);
        check("single_count", 32'(op_count), 32'd1);
        check("single_drain", 32'(rsp_valid), 32'd0);
        step();

        // Round-robin fairness from a fresh pointer.
        pulse_reset();
        for (int i = 0; i < NUM_REQ; i++) set_op(i, 8'(8'h11 * (i + 1)), 8'(8'hF0 - i));
        req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("rr_grant", 32'(req_ready), 32'd1 << rr_exp[k]);
            if (k > 0) begin
                check("rr_rsp_valid", 32'(rsp_valid), 32'd1);
                check("rr_rsp_id", 32'(rsp_id), 32'(rr_exp[k-1]));
            end
            step();
        end
        req_valid = 4'b0000;
        @(negedge clk);
        check("rr_last_id", 32'(rsp_id), 32'd3);
        step();
        @(negedge clk);
        check("rr_count", 32'(op_count), 32'd8);
        step();

        // Backpressure: pointer is 0; requesters 1 and 2 valid.
        set_op(1, 8'h3C, 8'h55);
        set_op(2, 8'hF0, 8'h0F);
        req_valid = 4'b0110;
        rsp_ready = 1'b0;
        @(negedge clk);
        check("bp_first_grant", 32'(req_ready), 32'b0010);
        step();
        set_op(1, 8'h00, 8'h00);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("bp_ready_zero", 32'(req_ready), 32'b0000);
            check("bp_id_stable", 32'(rsp_id), 32'd1);
            check("bp_data_stable", 32'(rsp_data), 32'h69);
            step();
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_release_grant", 32'(req_ready), 32'b0100);
        step();
        req_valid = 4'b0000;
        @(negedge clk);
        check("bp_id2", 32'(rsp_id), 32'd2);
        check("bp_data2", 32'(rsp_data), 32'hFF);
        step();
        @(negedge clk);
        check("bp_count", 32'(op_count), 32'd10);
        step();

        // Pointer after skip: a grant to requester 1 leaves the pointer at 2.
        req_valid = 4'b0010;
        step();
        set_op(0, 8'h12, 8'h34);
        set_op(3, 8'hC3, 8'h81);
        req_valid = 4'b1001;
        @(negedge clk);
        check("skip_first", 32'(req_ready), 32'b1000);
        step();
        @(negedge clk);
        check("skip_second", 32'(req_ready), 32'b0001);
        check("skip_id3", 32'(rsp_id), 32'd3);
        check("skip_data3", 32'(rsp_data), 32'h42);
        step();
        req_valid = 4'b0000;
        @(negedge clk);
        check("skip_id0", 32'(rsp_id), 32'd0);
        check("skip_data0", 32'(rsp_data), 32'h26);
        step();
        @(negedge clk);
        check("skip_count", 32'(op_count), 32'd13);
        step();

        // Mid-operation reset while a result is held.
        req_valid = 4'b0100;
        rsp_ready = 1'b0;
        step();
        req_valid = 4'b0000;
        @(negedge clk);
        check("mid_hold", 32'(rsp_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_async_valid", 32'(rsp_valid), 32'd0);
        check("mid_async_count", 32'(op_count), 32'd0);
        check("mid_async_ready", 32'(req_ready), 32'b0000);
        step();
        rst_n = 1'b1;
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("mid_prio0", 32'(req_ready), 32'b0001);
        step();
        req_valid = 4'b0000;
        step();
        step();

        // Counter wrap.
        pulse_reset();
        req_valid = 4'b0001;
        rsp_ready = 1'b1;
        repeat (65535) step();
        req_valid = 4'b0000;
        step();
        @(negedge clk);
        check("wrap_max", 32'(op_count), 32'hFFFF);
        step();
        req_valid = 4'b0001;
        step();
        req_valid = 4'b0000;
        step();
        @(negedge clk);
        check("wrap_zero", 32'(op_count), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
